// File: rtl/exception_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exception_commit_pkg
// Description : Exception codes, CP0 register indices and FSM state encoding
//               shared by the exception commit block.
// Revision    : 1.0 - initial release
// ============================================================================
package exception_commit_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int CP0_BADVADDR_IDX = 8;
    localparam int CP0_STATUS_IDX   = 12;
    localparam int CP0_CAUSE_IDX    = 13;
    localparam int CP0_EPC_IDX      = 14;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ENTRY    = 2'd1;
    localparam logic [1:0] ST_ERET_WR  = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

endpackage
`default_nettype wire

// File: rtl/exception_commit_int_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : int_synchronizer
// Description : SYNC_STAGES-deep per-bit flop chain for asynchronous
//               interrupt lines, cleared by asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module int_synchronizer #(
    parameter int NBITS       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] d,
    output logic [NBITS-1:0] q
);

    logic [NBITS-1:0] r_chain [SYNC_STAGES];

    generate
        for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_chain[0] <= '0;
                    else     r_chain[0] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_chain[s] <= '0;
                    else     r_chain[s] <= r_chain[s-1];
                end
            end
        end
    endgenerate

    assign q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exception_commit.sv
`default_nettype none
// ============================================================================
// Module      : exception_commit
// Description : Picks the winning exception/interrupt/ERET at commit, drives
//               the CP0 write sequence, flushes and redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_commit
    import exception_commit_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ext_int,
    input  logic             commit_valid,
    input  logic [WIDTH-1:0] commit_pc,
    input  logic             commit_in_ds,
    input  logic             exc_adel_if,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel_ld,
    input  logic             exc_ades_st,
    input  logic [WIDTH-1:0] data_vaddr,
    input  logic             commit_eret,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] cp0_we,
    output logic [4:0]       cp0_exc_code,
    output logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_badaddr,
    output logic             cp0_bd,
    output logic             cp0_exl,
    output logic [5:0]       cp0_hw_int,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             busy
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [4:0]       r_code;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_badaddr;
    logic             r_bd;
    logic             r_addr_err;
    logic [WIDTH-1:0] r_redirect_pc;

    logic             w_int_pending;
    logic             w_any_exc;
    logic             w_accept;
    logic             w_take_exc;
    logic             w_take_eret;
    logic [4:0]       w_code;
    logic             w_addr_err;
    logic             w_unused_status;

    int_synchronizer #(
        .NBITS       (6),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_int),
        .q   (cp0_hw_int)
    );

    assign w_unused_status = ^{status_in[WIDTH-1:16], status_in[9:2]};

    assign w_int_pending = status_in[0] & ~status_in[1] & (|(cp0_hw_int & status_in[15:10]));
    assign w_any_exc     = w_int_pending | exc_adel_if | exc_ri | exc_ov | exc_sys
                         | exc_bp | exc_adel_ld | exc_ades_st;
    // Gated by rst so flush cannot leak out combinationally while reset is held.
    assign w_accept      = ~rst & (r_state == ST_IDLE) & commit_valid;
    assign w_take_exc    = w_accept & w_any_exc;
    assign w_take_eret   = w_accept & commit_eret & ~w_any_exc;

    always_comb begin
        w_code     = EXC_ADES;
        w_addr_err = 1'b0;
        if (w_int_pending)    w_code = EXC_INT;
        else if (exc_adel_if) begin w_code = EXC_ADEL; w_addr_err = 1'b1; end
        else if (exc_ri)      w_code = EXC_RI;
        else if (exc_ov)      w_code = EXC_OV;
        else if (exc_sys)     w_code = EXC_SYS;
        else if (exc_bp)      w_code = EXC_BP;
        else if (exc_adel_ld) begin w_code = EXC_ADEL; w_addr_err = 1'b1; end
        else if (exc_ades_st) begin w_code = EXC_ADES; w_addr_err = 1'b1; end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_code        <= '0;
            r_epc         <= '0;
            r_badaddr     <= '0;
            r_bd          <= 1'b0;
            r_addr_err    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_exc) begin
                r_code     <= w_code;
                // Modulo subtraction: a delay slot at PC 0 wraps to the top.
                r_epc      <= commit_in_ds ? commit_pc - WIDTH'(4) : commit_pc;
                r_bd       <= commit_in_ds;
                r_badaddr  <= exc_adel_if ? commit_pc : data_vaddr;
                r_addr_err <= w_addr_err;
            end
            if (r_state == ST_ENTRY)   r_redirect_pc <= EXC_VECTOR;
            if (r_state == ST_ERET_WR) r_redirect_pc <= epc_in;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        cp0_we         = '0;
        cp0_exc_code   = '0;
        cp0_epc        = '0;
        cp0_badaddr    = '0;
        cp0_bd         = 1'b0;
        cp0_exl        = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take_exc) begin
                    flush       = 1'b1;
                    w_state_nxt = ST_ENTRY;
                end else if (w_take_eret) begin
                    flush       = 1'b1;
                    w_state_nxt = ST_ERET_WR;
                end
            end
            ST_ENTRY: begin
                cp0_we[CP0_STATUS_IDX] = 1'b1;
                cp0_we[CP0_CAUSE_IDX]  = 1'b1;
                cp0_we[CP0_EPC_IDX]    = 1'b1;
                cp0_exl                = 1'b1;
                cp0_exc_code           = r_code;
                cp0_epc                = r_epc;
                cp0_bd                 = r_bd;
                if (r_addr_err) begin
                    cp0_we[CP0_BADVADDR_IDX] = 1'b1;
                    cp0_badaddr              = r_badaddr;
                end
                flush       = 1'b1;
                w_state_nxt = ST_REDIRECT;
            end
            ST_ERET_WR: begin
                cp0_we[CP0_STATUS_IDX] = 1'b1;
                flush                  = 1'b1;
                w_state_nxt            = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_redirect_pc;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exception_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exception_commit
// Description : Directed vector table plus hand sequences for exception_commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_commit;

    localparam int WIDTH = 32;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       ext_int;
    logic             commit_valid;
    logic [WIDTH-1:0] commit_pc;
    logic             commit_in_ds;
    logic             exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades_st;
    logic [WIDTH-1:0] data_vaddr;
    logic             commit_eret;
    logic [WIDTH-1:0] status_in;
    logic [WIDTH-1:0] epc_in;
    logic [WIDTH-1:0] cp0_we;
    logic [4:0]       cp0_exc_code;
    logic [WIDTH-1:0] cp0_epc;
    logic [WIDTH-1:0] cp0_badaddr;
    logic             cp0_bd;
    logic             cp0_exl;
    logic [5:0]       cp0_hw_int;
    logic             flush;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    exception_commit #(
        .WIDTH       (WIDTH),
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_int        (ext_int),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_in_ds   (commit_in_ds),
        .exc_adel_if    (exc_adel_if),
        .exc_ri         (exc_ri),
        .exc_ov         (exc_ov),
        .exc_sys        (exc_sys),
        .exc_bp         (exc_bp),
        .exc_adel_ld    (exc_adel_ld),
        .exc_ades_st    (exc_ades_st),
        .data_vaddr     (data_vaddr),
        .commit_eret    (commit_eret),
        .status_in      (status_in),
        .epc_in         (epc_in),
        .cp0_we         (cp0_we),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_epc        (cp0_epc),
        .cp0_badaddr    (cp0_badaddr),
        .cp0_bd         (cp0_bd),
        .cp0_exl        (cp0_exl),
        .cp0_hw_int     (cp0_hw_int),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // flags order: {adel_if, ri, ov, sys, bp, adel_ld, ades_st}
    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic [6:0]  flags;
        logic [31:0] vaddr;
        logic        eret;
        logic [31:0] epc_src;
        logic        x_eret;
        logic [4:0]  x_code;
        logic [31:0] x_epc;
        logic        x_bd;
        logic        x_we8;
        logic [31:0] x_badaddr;
        logic [31:0] x_rpc;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        commit_valid = 0; commit_pc = '0; commit_in_ds = 0; commit_eret = 0;
        {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades_st} = '0;
        data_vaddr = '0;
    endtask

    function automatic logic [31:0] exc_we(input logic we8);
        return (32'h1 << 12) | (32'h1 << 13) | (32'h1 << 14) | (we8 ? 32'h100 : 32'h0);
    endfunction

    initial begin
        rst = 1; ext_int = '0; status_in = '0; epc_in = '0;
        clear_commit();

        //              pc            ds  flags       vaddr         eret epc_src       x_eret code   x_epc         bd we8 x_badaddr     x_rpc
        vt[0]  = '{32'h80001000, 0, 7'b0010000, 32'h0,        0, 32'h0,        0, 5'h0C, 32'h80001000, 0, 0, 32'h0,        VEC};
        vt[1]  = '{32'h80002004, 1, 7'b0000010, 32'h00000003, 0, 32'h0,        0, 5'h04, 32'h80002000, 1, 1, 32'h00000003, VEC};
        vt[2]  = '{32'h80008000, 0, 7'b0000000, 32'h0,        1, 32'h80003000, 1, 5'h00, 32'h0,        0, 0, 32'h0,        32'h80003000};
        vt[3]  = '{32'h80004000, 0, 7'b0001000, 32'h0,        1, 32'h80003000, 0, 5'h08, 32'h80004000, 0, 0, 32'h0,        VEC};
        vt[4]  = '{32'h80005000, 0, 7'b1110000, 32'h1234,     0, 32'h0,        0, 5'h04, 32'h80005000, 0, 1, 32'h80005000, VEC};
        vt[5]  = '{32'h80006000, 0, 7'b0000001, 32'h80007002, 0, 32'h0,        0, 5'h05, 32'h80006000, 0, 1, 32'h80007002, VEC};
        vt[6]  = '{32'h00000000, 1, 7'b0000100, 32'h0,        0, 32'h0,        0, 5'h09, 32'hFFFFFFFC, 1, 0, 32'h0,        VEC};
        vt[7]  = '{32'h80009000, 0, 7'b0110000, 32'h0,        0, 32'h0,        0, 5'h0A, 32'h80009000, 0, 0, 32'h0,        VEC};
        vt[8]  = '{32'h8000A000, 0, 7'b0011000, 32'h0,        0, 32'h0,        0, 5'h0C, 32'h8000A000, 0, 0, 32'h0,        VEC};
        vt[9]  = '{32'h8000B000, 0, 7'b0001100, 32'h0,        0, 32'h0,        0, 5'h08, 32'h8000B000, 0, 0, 32'h0,        VEC};
        vt[10] = '{32'h8000C000, 0, 7'b0000110, 32'h5555,     0, 32'h0,        0, 5'h09, 32'h8000C000, 0, 0, 32'h0,        VEC};
        vt[11] = '{32'h8000D004, 1, 7'b0000011, 32'h00000011, 0, 32'h0,        0, 5'h04, 32'h8000D000, 1, 1, 32'h00000011, VEC};

        #2;
        check("reset_we", cp0_we, 32'h0);
        check("reset_flush", {31'h0, flush}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_hw_int", {26'h0, cp0_hw_int}, 32'h0);
        check("reset_redirect", {31'h0, redirect_valid}, 32'h0);
        tick(); tick();
        rst = 0;
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 12; i++) begin
            commit_valid = 1; commit_pc = vt[i].pc; commit_in_ds = vt[i].ds;
            {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades_st} = vt[i].flags;
            data_vaddr = vt[i].vaddr; commit_eret = vt[i].eret; epc_in = vt[i].epc_src;
            #2;
            check($sformatf("v%0d_T_flush", i), {31'h0, flush}, 32'h1);
            check($sformatf("v%0d_T_busy", i), {31'h0, busy}, 32'h0);
            tick();
            clear_commit();
            #2;
            check($sformatf("v%0d_T1_we", i), cp0_we, vt[i].x_eret ? (32'h1 << 12) : exc_we(vt[i].x_we8));
            check($sformatf("v%0d_T1_code", i), {27'h0, cp0_exc_code}, {27'h0, vt[i].x_code});
            check($sformatf("v%0d_T1_epc", i), cp0_epc, vt[i].x_epc);
            check($sformatf("v%0d_T1_bd", i), {31'h0, cp0_bd}, {31'h0, vt[i].x_bd});
            check($sformatf("v%0d_T1_badaddr", i), cp0_badaddr, vt[i].x_badaddr);
            check($sformatf("v%0d_T1_exl", i), {31'h0, cp0_exl}, {31'h0, ~vt[i].x_eret});
            check($sformatf("v%0d_T1_flush", i), {31'h0, flush}, 32'h1);
            check($sformatf("v%0d_T1_busy", i), {31'h0, busy}, 32'h1);
            check($sformatf("v%0d_T1_rv", i), {31'h0, redirect_valid}, 32'h0);
            tick();
            epc_in = 32'hDEADBEEF;
            #2;
            check($sformatf("v%0d_T2_rv", i), {31'h0, redirect_valid}, 32'h1);
            check($sformatf("v%0d_T2_rpc", i), redirect_pc, vt[i].x_rpc);
            check($sformatf("v%0d_T2_we", i), cp0_we, 32'h0);
            check($sformatf("v%0d_T2_flush", i), {31'h0, flush}, 32'h0);
            tick();
            #2;
            check($sformatf("v%0d_T3_busy", i), {31'h0, busy}, 32'h0);
            check($sformatf("v%0d_T3_rv", i), {31'h0, redirect_valid}, 32'h0);
        end

        // ---------------- interrupt vs RI, sync latency ----------------
        status_in = 32'h0000FF01;
        ext_int = 6'b000001;
        #2;
        check("int_sync_0clk", {26'h0, cp0_hw_int}, 32'h0);
        tick();
        check("int_sync_1clk", {26'h0, cp0_hw_int}, 32'h0);
        tick();
        check("int_sync_2clk", {26'h0, cp0_hw_int}, 32'h1);
        commit_valid = 1; commit_pc = 32'h8000E000; exc_ri = 1;
        #2;
        check("int_T_flush", {31'h0, flush}, 32'h1);
        tick();
        clear_commit();
        #2;
        check("int_T1_code", {27'h0, cp0_exc_code}, 32'h0);
        check("int_T1_we", cp0_we, exc_we(1'b0));
        check("int_T1_epc", cp0_epc, 32'h8000E000);
        tick(); tick();

        // ---------------- interrupt masked by EXL ----------------
        status_in = 32'h0000FF03;
        commit_valid = 1; commit_pc = 32'h8000F000;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("exl_noflush%0d", c), {31'h0, flush}, 32'h0);
            tick();
        end
        check("exl_busy", {31'h0, busy}, 32'h0);
        status_in = 32'h0000FF01;
        commit_valid = 0;
        #2;
        check("nocommit_noflush", {31'h0, flush}, 32'h0);
        tick();
        check("nocommit_busy", {31'h0, busy}, 32'h0);
        commit_valid = 1;
        #2;
        check("exl_clear_flush", {31'h0, flush}, 32'h1);
        tick();
        clear_commit();
        ext_int = '0; status_in = '0;
        #2;
        check("exl_clear_code", {27'h0, cp0_exc_code}, 32'h0);
        check("exl_clear_epc", cp0_epc, 32'h8000F000);
        tick(); tick(); tick();

        // ---------------- busy: repeated Bp commits ignored ----------------
        commit_valid = 1; exc_bp = 1; commit_pc = 32'h80010000;
        tick();
        commit_pc = 32'h80010004;
        #2;
        check("busy_T1_epc", cp0_epc, 32'h80010000);
        check("busy_T1_code", {27'h0, cp0_exc_code}, 32'h09);
        tick();
        commit_pc = 32'h80010008;
        #2;
        check("busy_T2_rv", {31'h0, redirect_valid}, 32'h1);
        check("busy_T2_flush", {31'h0, flush}, 32'h0);
        tick();
        clear_commit();
        #2;
        check("busy_T3_idle", {31'h0, busy}, 32'h0);
        check("busy_T3_noflush", {31'h0, flush}, 32'h0);
        tick();
        check("busy_T4_we", cp0_we, 32'h0);

        // ---------------- reset during ENTRY ----------------
        ext_int = 6'h3F;
        tick(); tick();
        check("rst_pre_hw_int", {26'h0, cp0_hw_int}, 32'h3F);
        commit_valid = 1; exc_ov = 1; commit_pc = 32'h80020000;
        tick();
        clear_commit();
        ext_int = '0;
        #1;
        check("rst_pre_entry_we", cp0_we, exc_we(1'b0));
        rst = 1;
        #1;
        check("rst_mid_we", cp0_we, 32'h0);
        check("rst_mid_flush", {31'h0, flush}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_exl", {31'h0, cp0_exl}, 32'h0);
        check("rst_mid_hw_int", {26'h0, cp0_hw_int}, 32'h0);
        tick();
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            #2;
            check($sformatf("rst_after_rv%0d", c), {31'h0, redirect_valid}, 32'h0);
            check($sformatf("rst_after_we%0d", c), cp0_we, 32'h0);
            check($sformatf("rst_after_hw%0d", c), {26'h0, cp0_hw_int}, 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
